alu_divider: RTL and testbench

Parametrised sequential integer divider, successor to the fixed 8-bit ALU divide unit. Computes quotient and remainder of WIDTH-bit operands in signed or unsigned mode, one restoring step per clock, with a start/ready/valid handshake, abort and defined divide-by-zero/overflow results. Sits in the arithmetic group beside the other multi-cycle ALU units and is sequenced by the ALU controller.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_divider_if.sv | 26 ++
 rtl/alu_div_step.sv | 21 ++
 rtl/alu_divider.sv | 94 +++++++++
 tb/tb_alu_divider.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the sequential ALU divider
package alu_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;

   // widest operand the two's-complement helper handles
   localparam int MAXW = 64;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // conditional negate; callers truncate to their own width, which keeps abs/neg exact mod 2^WIDTH
   function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] x, input logic n);
      return n ? -x : x;
   endfunction

endpackage

// File: rtl/alu_divider_if.sv
// alu_divider_if: request/response bundle between the ALU controller and the divider
interface alu_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             is_signed;
   logic             abort;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             out_valid;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output start, is_signed, abort, a, b,
      input  ready, out_valid, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, is_signed, abort, a, b,
      output ready, out_valid, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/alu_div_step.sv
// alu_div_step: one combinational restoring-division step on {R,Q} against divisor M
module alu_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);
   logic [WIDTH:0] sh;
   logic [WIDTH:0] trial;

   // shift in the next dividend bit, keep the trial difference only when it stays non-negative
   always_comb begin
      sh     = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
      trial  = sh - {1'b0, m};
      r_next = trial[WIDTH] ? sh : trial;
      q_next = {q[WIDTH-2:0], ~trial[WIDTH]};
   end
endmodule

// File: rtl/alu_divider.sv
// alu_divider: sequential signed/unsigned divider, one restoring step per clock
module alu_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          reset_n,
   alu_divider_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state;
   logic [CW-1:0]    cnt;
   logic             sa, sb, dz, ov;
   logic [WIDTH-1:0] q, m, a_l, q_n;
   logic [WIDTH:0]   r, r_n;
   logic             sgn_a, sgn_b, dz_c, ov_c;

   assign sgn_a = bus.is_signed & bus.a[WIDTH-1];
   assign sgn_b = bus.is_signed & bus.b[WIDTH-1];
   assign dz_c  = bus.b == '0;
   assign ov_c  = bus.is_signed && bus.a == MIN && bus.b == '1;

   alu_div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q      (q),
      .m      (m),
      .r_next (r_n),
      .q_next (q_n)
   );

   // control FSM, datapath registers and registered result outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         cnt             <= '0;
         sa              <= 1'b0;
         sb              <= 1'b0;
         dz              <= 1'b0;
         ov              <= 1'b0;
         q               <= '0;
         m               <= '0;
         a_l             <= '0;
         r               <= '0;
         bus.ready       <= 1'b1;
         bus.out_valid   <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         bus.overflow    <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         if (state != IDLE && bus.abort) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  sa        <= sgn_a;
                  sb        <= sgn_b;
                  q         <= WIDTH'(cond_neg(MAXW'(bus.a), sgn_a));
                  m         <= WIDTH'(cond_neg(MAXW'(bus.b), sgn_b));
                  a_l       <= bus.a;
                  r         <= '0;
                  cnt       <= '0;
                  dz        <= dz_c;
                  ov        <= ov_c;
                  bus.ready <= 1'b0;
                  state     <= (dz_c || ov_c) ? FIX : CALC;
               end
               CALC: begin
                  r   <= r_n;
                  q   <= q_n;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH - 1)) state <= FIX;
               end
               FIX: if (bus.out_valid) begin
                  state     <= IDLE;
                  bus.ready <= 1'b1;
               end else begin
                  bus.out_valid   <= 1'b1;
                  bus.quotient    <= dz ? '1 : ov ? MIN : WIDTH'(cond_neg(MAXW'(q), sa ^ sb));
                  bus.remainder   <= dz ? a_l : ov ? '0 : WIDTH'(cond_neg(MAXW'(r[WIDTH-1:0]), sa));
                  bus.div_by_zero <= dz;
                  bus.overflow    <= ov;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: scoreboard bench for the divider at WIDTH 8, 3 and 16
module tb_alu_divider;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
   } exp_t;

   typedef struct {
      string      nm;
      logic       sg;
      logic [7:0] a;
      logic [7:0] b;
   } op_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_divider_if #(.WIDTH(8))  i8 ();
   alu_divider_if #(.WIDTH(3))  i3 ();
   alu_divider_if #(.WIDTH(16)) i16 ();

   alu_divider #(.WIDTH(8))  u8  (.clk(clk), .reset_n(reset_n), .bus(i8.slave));
   alu_divider #(.WIDTH(3))  u3  (.clk(clk), .reset_n(reset_n), .bus(i3.slave));
   alu_divider #(.WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(i16.slave));

   // reference: integer division on sign-interpreted values, truncating toward zero
   function automatic exp_t model(input int w, input logic sg, input logic [15:0] a, input logic [15:0] b);
      exp_t   e;
      longint full, msk, av, bv;
      full = longint'(1) << w;
      msk  = full - 1;
      av   = longint'(a) & msk;
      bv   = longint'(b) & msk;
      if (sg && av >= full / 2) av -= full;
      if (sg && bv >= full / 2) bv -= full;
      e = '0;
      if (bv == 0) begin
         e.q  = 16'(msk);
         e.r  = 16'(av & msk);
         e.dz = 1'b1;
      end else if (sg && av == -(full / 2) && bv == -1) begin
         e.q  = 16'(full / 2);
         e.ov = 1'b1;
      end else begin
         e.q = 16'((av / bv) & msk);
         e.r = 16'((av % bv) & msk);
      end
      return e;
   endfunction

   function automatic exp_t got(input int w);
      exp_t g;
      if (w == 3)       g = '{q: 16'(i3.quotient),  r: 16'(i3.remainder),  dz: i3.div_by_zero,  ov: i3.overflow};
      else if (w == 16) g = '{q: i16.quotient,      r: i16.remainder,      dz: i16.div_by_zero, ov: i16.overflow};
      else              g = '{q: 16'(i8.quotient),  r: 16'(i8.remainder),  dz: i8.div_by_zero,  ov: i8.overflow};
      return g;
   endfunction

   function automatic logic vld(input int w);
      return (w == 3) ? i3.out_valid : (w == 16) ? i16.out_valid : i8.out_valid;
   endfunction

   function automatic logic [15:0] pick(input int w);
      logic [31:0] mn, ones;
      mn   = 32'd1 << (w - 1);
      ones = (32'd1 << w) - 1;
      case ($urandom_range(0, 5))
         0:       return 16'd0;
         1:       return 16'(mn);
         2:       return 16'(ones);
         3:       return 16'd1;
         default: return 16'($urandom & ones);
      endcase
   endfunction

   task automatic issue(input int w, input logic sg, input logic [15:0] a, input logic [15:0] b, input logic push);
      @(negedge clk);
      if (w == 3) begin
         i3.start = 1'b1; i3.is_signed = sg; i3.a = a[2:0]; i3.b = b[2:0];
      end else if (w == 16) begin
         i16.start = 1'b1; i16.is_signed = sg; i16.a = a; i16.b = b;
      end else begin
         i8.start = 1'b1; i8.is_signed = sg; i8.a = a[7:0]; i8.b = b[7:0];
      end
      if (push) sb.push_back(model(w, sg, a, b));
      @(negedge clk);
      i3.start = 1'b0; i8.start = 1'b0; i16.start = 1'b0; i8.abort = 1'b0;
      i3.a = 3'($urandom); i3.b = 3'($urandom); i3.is_signed = ~i3.is_signed;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.is_signed = ~i8.is_signed;
      i16.a = 16'($urandom); i16.b = 16'($urandom); i16.is_signed = ~i16.is_signed;
   endtask

   task automatic wait_v(input int w, output int lat);
      lat = 1;
      while (!vld(w) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (got(8) !== '0 || got(3) !== '0 || got(16) !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got w8=%h w3=%h w16=%h, expected all zero", got(8), got(3), got(16));
      end
      n_checks++;
      if (i8.ready !== 1'b1 || i8.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: got ready=%b out_valid=%b, expected ready=1 out_valid=0", i8.ready, i8.out_valid);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      op_t  ops[10];
      exp_t e, g;
      int   lat;
      ops = '{'{"u200_7", 1'b0, 8'd200, 8'd7}, '{"u255_1", 1'b0, 8'd255, 8'd1},
              '{"u13_200", 1'b0, 8'd13, 8'd200}, '{"u128_255", 1'b0, 8'h80, 8'hFF},
              '{"s-7_2", 1'b1, 8'hF9, 8'd2}, '{"s7_-2", 1'b1, 8'd7, 8'hFE},
              '{"s-128_3", 1'b1, 8'h80, 8'd3}, '{"dz_55", 1'b0, 8'h55, 8'd0},
              '{"ovf_-128_-1", 1'b1, 8'h80, 8'hFF}, '{"sdz_-128", 1'b1, 8'h80, 8'd0}};
      foreach (ops[i]) begin
         issue(8, ops[i].sg, 16'(ops[i].a), 16'(ops[i].b), 1'b1);
         wait_v(8, lat);
         e = sb.pop_front();
         g = got(8);
         n_checks++;
         if (!vld(8)) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid low after %0d cycles, expected a result", ops[i].nm, lat);
         end else if (g !== e) begin
            n_fail++;
            $display("FAIL %s result: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                     ops[i].nm, g.q, g.r, g.dz, g.ov, e.q, e.r, e.dz, e.ov);
         end
         n_checks++;
         if (lat !== ((e.dz || e.ov) ? 2 : 10)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, expected %0d", ops[i].nm, lat, (e.dz || e.ov) ? 2 : 10);
         end
         @(negedge clk);
         n_checks++;
         if (i8.out_valid !== 1'b0 || i8.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pulse: got out_valid=%b ready=%b next cycle, expected 0 and 1", ops[i].nm, i8.out_valid, i8.ready);
         end
      end
   endtask

   task automatic test_abort();
      exp_t e, g, prev;
      int   lat;
      logic seen;
      issue(8, 1'b0, 16'd37, 16'd5, 1'b1);
      wait_v(8, lat);
      prev = sb.pop_front();
      g = got(8);
      n_checks++;
      if (g !== prev) begin
         n_fail++;
         $display("FAIL abort_setup: got q=%h r=%h, expected q=%h r=%h", g.q, g.r, prev.q, prev.r);
      end
      issue(8, 1'b0, 16'd200, 16'd7, 1'b0);
      repeat (4) @(negedge clk);
      i8.abort = 1'b1;
      @(negedge clk);
      i8.abort = 1'b0;
      n_checks++;
      if (i8.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_ready: got ready=%b, expected 1", i8.ready);
      end
      g = got(8);
      n_checks++;
      if (g !== prev) begin
         n_fail++;
         $display("FAIL abort_hold: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b", g.q, g.r, g.dz, g.ov, prev.q, prev.r, prev.dz, prev.ov);
      end
      seen = 1'b0;
      repeat (14) begin
         if (i8.out_valid) seen = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL abort_no_valid: got an out_valid pulse, expected none");
      end
      i8.abort = 1'b1;
      issue(8, 1'b0, 16'd100, 16'd10, 1'b1);
      wait_v(8, lat);
      e = sb.pop_front();
      g = got(8);
      n_checks++;
      if (!vld(8) || g !== e) begin
         n_fail++;
         $display("FAIL after_abort_100_10: got valid=%b q=%h r=%h, expected q=%h r=%h", vld(8), g.q, g.r, e.q, e.r);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e, g;
      int   lat, c1, c2, t;
      logic seen;
      c1 = 0;
      c2 = 0;
      @(negedge clk);
      i8.start = 1'b1; i8.is_signed = 1'b0; i8.a = 8'd200; i8.b = 8'd7;
      sb.push_back(model(8, 1'b0, 16'd200, 16'd7));
      @(negedge clk);
      i8.a = 8'd100; i8.b = 8'd9;
      sb.push_back(model(8, 1'b0, 16'd100, 16'd9));
      for (int k = 0; k < 2; k++) begin
         wait_v(8, lat);
         e = sb.pop_front();
         g = got(8);
         n_checks++;
         if (!vld(8) || g !== e) begin
            n_fail++;
            $display("FAIL b2b_op%0d: got valid=%b q=%h r=%h, expected q=%h r=%h", k, vld(8), g.q, g.r, e.q, e.r);
         end
         if (k == 0) begin
            c1 = cyc;
            t = 0;
            @(negedge clk);
            while (!i8.ready && t < 50) begin
               @(negedge clk);
               t++;
            end
            @(negedge clk);
            i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
         end else c2 = cyc;
      end
      n_checks++;
      if (c2 - c1 !== 11) begin
         n_fail++;
         $display("FAIL b2b_throughput: got %0d cycles between results, expected 11", c2 - c1);
      end
      seen = 1'b0;
      @(negedge clk);
      repeat (15) begin
         if (i8.out_valid) seen = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL b2b_extra_result: got an unrequested out_valid, expected none");
      end
   endtask

   task automatic test_async_reset();
      issue(8, 1'b0, 16'd200, 16'd7, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (got(8) !== '0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got %h, expected zero", got(8));
      end
      n_checks++;
      if (i8.ready !== 1'b1 || i8.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_handshake: got ready=%b out_valid=%b, expected 1 and 0", i8.ready, i8.out_valid);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_sweep();
      int          ws[2];
      exp_t        e, g;
      int          lat;
      logic        sg;
      logic [15:0] a, b, mn, ones;
      ws = '{3, 16};
      for (int j = 0; j < 2; j++) begin
         mn   = 16'(32'd1 << (ws[j] - 1));
         ones = 16'((32'd1 << ws[j]) - 1);
         for (int n = 0; n < 40; n++) begin
            sg = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            a  = pick(ws[j]);
            b  = pick(ws[j]);
            if (n == 0) begin a = mn;   b = ones; end
            if (n == 1) begin a = mn;   b = 16'd1; end
            if (n == 2) begin a = ones; b = mn; end
            if (n == 3) begin a = mn;   b = 16'd0; end
            issue(ws[j], sg, a, b, 1'b1);
            wait_v(ws[j], lat);
            e = sb.pop_front();
            g = got(ws[j]);
            n_checks++;
            if (!vld(ws[j]) || g !== e) begin
               n_fail++;
               $display("FAIL sweep_w%0d_%0d (s=%b a=%h b=%h): got valid=%b q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                        ws[j], n, sg, a, b, vld(ws[j]), g.q, g.r, g.dz, g.ov, e.q, e.r, e.dz, e.ov);
            end
            n_checks++;
            if (lat !== ((e.dz || e.ov) ? 2 : ws[j] + 2)) begin
               n_fail++;
               $display("FAIL sweep_w%0d_%0d latency: got %0d, expected %0d", ws[j], n, lat, (e.dz || e.ov) ? 2 : ws[j] + 2);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      i8.start = 1'b0;  i8.is_signed = 1'b0;  i8.abort = 1'b0;  i8.a = '0;  i8.b = '0;
      i3.start = 1'b0;  i3.is_signed = 1'b0;  i3.abort = 1'b0;  i3.a = '0;  i3.b = '0;
      i16.start = 1'b0; i16.is_signed = 1'b0; i16.abort = 1'b0; i16.a = '0; i16.b = '0;
      test_reset();
      test_basic();
      test_abort();
      test_back_to_back();
      test_async_reset();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
